// File: rtl/emu_host_sequencer.sv
// Host-side sequencer for an emulated DUT: collects stimulus bytes, writes them into the wrapper,
// pulses the DUT clock, reads the outputs back and streams them to the host. Option: EMU_MONITOR_EN adds led_emu.
module emu_host_sequencer #(
  parameter int NUM_STIM = 8,
  parameter int NUM_OUT  = 8,
  parameter int DUT_HOLD = 2
) (
  input  logic       clk_emu,
  input  logic       rst_emu,
  input  logic [7:0] s_data,
  input  logic       s_valid,
  output logic       s_ready,
  output logic [7:0] m_data,
  output logic       m_valid,
  input  logic       m_ready,
  output logic [7:0] Din_emu,
  output logic [2:0] Addr_emu,
  output logic       load_emu,
  output logic       get_emu,
  output logic       clk_dut,
  input  logic [7:0] Dout_emu,
  output logic       busy
`ifdef EMU_MONITOR_EN
  ,
  output logic       led_emu
`endif
);

  typedef enum logic [3:0] {
    IDLE   = 4'd0,
    RECV   = 4'd1,
    WRITE  = 4'd2,
    LOAD   = 4'd3,
    CLK_HI = 4'd4,
    CLK_LO = 4'd5,
    GET    = 4'd6,
    READ   = 4'd7,
    SEND   = 4'd8
  } state_t;

  localparam logic [3:0] LAST_STIM = 4'(NUM_STIM - 1);
  localparam logic [3:0] LAST_OUT  = 4'(NUM_OUT - 1);
  localparam logic [3:0] LAST_HOLD = 4'(DUT_HOLD - 1);
  localparam logic [3:0] READ_END  = 4'(NUM_OUT);

  state_t     state;
  logic [3:0] cnt;
  logic [3:0] cnt_next;
  logic [3:0] cnt_prev;
  logic [7:0] stim_buf [0:7];
  logic [7:0] out_buf  [0:7];

  assign cnt_next = cnt + 4'd1;
  assign cnt_prev = cnt - 4'd1;

  // Addresses beyond the stimulus array read as zero so the wrapper copy stays consistent.
  function automatic logic [7:0] stim_at(input logic [3:0] idx);
    if (idx < 4'(NUM_STIM)) begin
      return stim_buf[idx[2:0]];
    end else begin
      return 8'h00;
    end
  endfunction

  // Main sequencer FSM; every output is registered and updated with its state transition.
  always_ff @(posedge clk_emu) begin
    if (rst_emu) begin
      state    <= IDLE;
      cnt      <= 4'd0;
      s_ready  <= 1'b1;
      m_valid  <= 1'b0;
      m_data   <= 8'h00;
      Din_emu  <= 8'h00;
      Addr_emu <= 3'd0;
      load_emu <= 1'b0;
      get_emu  <= 1'b0;
      clk_dut  <= 1'b0;
      busy     <= 1'b0;
`ifdef EMU_MONITOR_EN
      led_emu  <= 1'b0;
`endif
      for (int i = 0; i < 8; i++) begin
        stim_buf[i] <= 8'h00;
        out_buf[i]  <= 8'h00;
      end
    end else begin
      case (state)
        IDLE: begin
          if (s_valid) begin
            stim_buf[0] <= s_data;
            Din_emu     <= s_data;
            busy        <= 1'b1;
            if (NUM_STIM == 1) begin
              state   <= WRITE;
              s_ready <= 1'b0;
              cnt     <= 4'd0;
            end else begin
              state <= RECV;
              cnt   <= 4'd1;
            end
          end
        end
        RECV: begin
          if (s_valid) begin
            stim_buf[cnt[2:0]] <= s_data;
            if (cnt == LAST_STIM) begin
              state   <= WRITE;
              s_ready <= 1'b0;
              cnt     <= 4'd0;
            end else begin
              cnt <= cnt_next;
            end
          end
        end
        WRITE: begin
          if (cnt == LAST_STIM) begin
            state    <= LOAD;
            load_emu <= 1'b1;
            Addr_emu <= 3'd0;
            Din_emu  <= stim_buf[0];
            cnt      <= 4'd0;
          end else begin
            cnt      <= cnt_next;
            Addr_emu <= cnt_next[2:0];
            Din_emu  <= stim_at(cnt_next);
          end
        end
        LOAD: begin
          state    <= CLK_HI;
          load_emu <= 1'b0;
          clk_dut  <= 1'b1;
          cnt      <= 4'd0;
        end
        CLK_HI: begin
          if (cnt == LAST_HOLD) begin
            state   <= CLK_LO;
            clk_dut <= 1'b0;
            cnt     <= 4'd0;
          end else begin
            cnt <= cnt_next;
          end
        end
        CLK_LO: begin
          if (cnt == LAST_HOLD) begin
            state   <= GET;
            get_emu <= 1'b1;
            cnt     <= 4'd0;
          end else begin
            cnt <= cnt_next;
          end
        end
        GET: begin
          state    <= READ;
          get_emu  <= 1'b0;
          Addr_emu <= 3'd0;
          Din_emu  <= stim_buf[0];
          cnt      <= 4'd0;
        end
        READ: begin
          // Dout_emu lags Addr_emu by one cycle, so slot cnt-1 is captured while cnt is addressed.
          if (cnt != 4'd0) begin
            out_buf[cnt_prev[2:0]] <= Dout_emu;
          end
          if (cnt == READ_END) begin
            state    <= SEND;
            m_valid  <= 1'b1;
            m_data   <= (NUM_OUT == 1) ? Dout_emu : out_buf[0];
            Addr_emu <= 3'd0;
            Din_emu  <= stim_buf[0];
            cnt      <= 4'd0;
          end else begin
            cnt <= cnt_next;
            if (cnt < LAST_OUT) begin
              Addr_emu <= cnt_next[2:0];
              Din_emu  <= stim_at(cnt_next);
            end
          end
        end
        SEND: begin
          if (m_ready) begin
            if (cnt == LAST_OUT) begin
              state   <= IDLE;
              m_valid <= 1'b0;
              m_data  <= 8'h00;
              s_ready <= 1'b1;
              busy    <= 1'b0;
              cnt     <= 4'd0;
`ifdef EMU_MONITOR_EN
              led_emu <= ~led_emu;
`endif
            end else begin
              cnt    <= cnt_next;
              m_data <= out_buf[cnt_next[2:0]];
            end
          end
        end
        default: begin
          state    <= IDLE;
          cnt      <= 4'd0;
          s_ready  <= 1'b1;
          m_valid  <= 1'b0;
          load_emu <= 1'b0;
          get_emu  <= 1'b0;
          clk_dut  <= 1'b0;
          busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_emu_host_sequencer.sv
// Directed bench: a default instance and a NUM_STIM=1/NUM_OUT=3/DUT_HOLD=1 instance,
// each with a behavioural wrapper returning 0xA0+k.
module tb_emu_host_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, s_valid, m_ready, sel;
  logic [7:0] s_data;

  logic       s_ready_a, m_valid_a, load_a, get_a, clkd_a, busy_a;
  logic [7:0] m_data_a, din_a, dout_a;
  logic [2:0] addr_a;
  logic       s_ready_b, m_valid_b, load_b, get_b, clkd_b, busy_b;
  logic [7:0] m_data_b, din_b, dout_b;
  logic [2:0] addr_b;
`ifdef EMU_MONITOR_EN
  logic       led_a, led_b;
`endif

  logic       s_ready_c, m_valid_c, load_c, get_c, clkd_c, busy_c;
  logic [7:0] m_data_c, din_c;
  logic [2:0] addr_c;

  assign s_ready_c = sel ? s_ready_b : s_ready_a;
  assign m_valid_c = sel ? m_valid_b : m_valid_a;
  assign load_c    = sel ? load_b    : load_a;
  assign get_c     = sel ? get_b     : get_a;
  assign clkd_c    = sel ? clkd_b    : clkd_a;
  assign busy_c    = sel ? busy_b    : busy_a;
  assign m_data_c  = sel ? m_data_b  : m_data_a;
  assign din_c     = sel ? din_b     : din_a;
  assign addr_c    = sel ? addr_b    : addr_a;

  emu_host_sequencer dut_a (
    .clk_emu(clk), .rst_emu(rst), .s_data(s_data), .s_valid(s_valid & ~sel), .s_ready(s_ready_a),
    .m_data(m_data_a), .m_valid(m_valid_a), .m_ready(m_ready & ~sel), .Din_emu(din_a),
    .Addr_emu(addr_a), .load_emu(load_a), .get_emu(get_a), .clk_dut(clkd_a),
    .Dout_emu(dout_a), .busy(busy_a)
`ifdef EMU_MONITOR_EN
    , .led_emu(led_a)
`endif
  );

  emu_host_sequencer #(.NUM_STIM(1), .NUM_OUT(3), .DUT_HOLD(1)) dut_b (
    .clk_emu(clk), .rst_emu(rst), .s_data(s_data), .s_valid(s_valid & sel), .s_ready(s_ready_b),
    .m_data(m_data_b), .m_valid(m_valid_b), .m_ready(m_ready & sel), .Din_emu(din_b),
    .Addr_emu(addr_b), .load_emu(load_b), .get_emu(get_b), .clk_dut(clkd_b),
    .Dout_emu(dout_b), .busy(busy_b)
`ifdef EMU_MONITOR_EN
    , .led_emu(led_b)
`endif
  );

  // Wrapper models: registered output array read, stimulus array written whenever not strobing.
  logic [7:0] stim_in_a [0:7];
  logic [7:0] stim_in_b [0:7];
  always @(posedge clk) begin
    dout_a <= 8'hA0 + {5'd0, addr_a};
    dout_b <= 8'hA0 + {5'd0, addr_b};
    if (!load_a && !get_a) stim_in_a[addr_a] <= din_a;
    if (!load_b && !get_b) stim_in_b[addr_b] <= din_b;
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic send(input int n, input logic [7:0] base, input bit gap);
    for (int i = 0; i < n; i++) begin
      if (gap) begin
        s_valid = 1'b0;
        @(negedge clk);
        check("s_ready_gap", 32'(s_ready_c), 32'd1);
      end
      s_data  = base + 8'(i);
      s_valid = 1'b1;
      check("s_ready_recv", 32'(s_ready_c), 32'd1);
      @(posedge clk);
      #1 s_valid = 1'b0;
      if (i < n - 1) @(negedge clk);
    end
  endtask

  task automatic trace(input int ns, input int h, input int no, input logic [7:0] base);
    int lat;
    int r;
    logic [7:0] e;
    lat = ns + 2 * h + no + 3;
    for (int j = 0; j <= lat; j++) begin
      @(negedge clk);
      check("load_emu", 32'(load_c), 32'(j == ns));
      check("get_emu", 32'(get_c), 32'(j == ns + 2 * h + 1));
      check("clk_dut", 32'(clkd_c), 32'(j > ns && j <= ns + h));
      check("m_valid_lat", 32'(m_valid_c), 32'(j == lat));
      check("s_ready_busy", 32'(s_ready_c), 32'd0);
      check("busy", 32'(busy_c), 32'd1);
      if (j < ns) begin
        check("write_addr", 32'(addr_c), 32'(j));
        check("write_din", 32'(din_c), 32'(base + 8'(j)));
      end
      r = j - (ns + 2 * h + 2);
      if (r >= 0 && r < no) begin
        e = (r < ns) ? base + 8'(r) : 8'h00;
        check("read_addr", 32'(addr_c), 32'(r));
        check("read_din", 32'(din_c), 32'(e));
      end
    end
  endtask

  task automatic recv(input int no, input int stall_at);
    int w;
    for (int k = 0; k < no; k++) begin
      w = 0;
      while (!m_valid_c && w < 50) begin
        @(negedge clk);
        w++;
      end
      check("m_valid_wait", 32'(m_valid_c), 32'd1);
      if (k == stall_at) begin
        m_ready = 1'b0;
        for (int s = 0; s < 10; s++) begin
          @(negedge clk);
          check("stall_valid", 32'(m_valid_c), 32'd1);
          check("stall_data", 32'(m_data_c), 32'(8'hA0 + 8'(k)));
        end
      end
      check("m_data", 32'(m_data_c), 32'(8'hA0 + 8'(k)));
      m_ready = 1'b1;
      @(negedge clk);
      m_ready = 1'b0;
    end
    check("done_busy", 32'(busy_c), 32'd0);
    check("done_s_ready", 32'(s_ready_c), 32'd1);
    check("done_m_valid", 32'(m_valid_c), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    int w;
    rst = 1'b1; s_valid = 1'b0; m_ready = 1'b0; sel = 1'b0; s_data = 8'h00;
    repeat (2) @(negedge clk);
    check("rst_s_ready", 32'(s_ready_c), 32'd1);
    check("rst_m_valid", 32'(m_valid_c), 32'd0);
    check("rst_m_data", 32'(m_data_c), 32'd0);
    check("rst_din", 32'(din_c), 32'd0);
    check("rst_addr", 32'(addr_c), 32'd0);
    check("rst_load", 32'(load_c), 32'd0);
    check("rst_get", 32'(get_c), 32'd0);
    check("rst_clk_dut", 32'(clkd_c), 32'd0);
    check("rst_busy", 32'(busy_c), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    send(8, 8'h10, 1'b0);
    trace(8, 2, 8, 8'h10);
    recv(8, 3);
    for (int k = 0; k < 8; k++) check("stim_in_a", 32'(stim_in_a[k]), 32'(8'h10 + 8'(k)));
    check("idle_din", 32'(din_c), 32'h10);

    send(8, 8'h20, 1'b0);
    w = 0;
    while (!clkd_c && w < 40) begin
      @(negedge clk);
      w++;
    end
    check("clk_hi_reached", 32'(clkd_c), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_clk_dut", 32'(clkd_c), 32'd0);
    check("abort_busy", 32'(busy_c), 32'd0);
    check("abort_s_ready", 32'(s_ready_c), 32'd1);
    check("abort_m_valid", 32'(m_valid_c), 32'd0);
    send(8, 8'h30, 1'b1);
    trace(8, 2, 8, 8'h30);
    recv(8, -1);
    for (int k = 0; k < 8; k++) check("stim_in_a2", 32'(stim_in_a[k]), 32'(8'h30 + 8'(k)));

    sel = 1'b1;
    @(negedge clk);
    send(1, 8'h5C, 1'b1);
    trace(1, 1, 3, 8'h5C);
    recv(3, 1);
    check("stim_in_b0", 32'(stim_in_b[0]), 32'h5C);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
